// File: rtl/switch_debounce_and_if.sv
// ---------------------------------------------------------------------------
// switch_debounce_and_if
// Groups the raw switch inputs and the conditioned switch/LED outputs of
// switch_debounce_and into one bundle. Clock and reset stay plain ports on
// the block itself.
//
//   i_Switch_1/2          raw, asynchronous push-button levels
//   o_Switch_1/2          debounced levels
//   o_Rise_1/2, o_Fall_1/2 one-cycle edge pulses of the debounced levels
//   o_LED_1               o_Switch_1 AND o_Switch_2
//   o_LED_2               toggles once per debounced press of switch 1
//
// Modports:
//   master - board / test side: drives the raw switches, observes outputs
//   slave  - the debouncer: reads raw switches, drives outputs
// ---------------------------------------------------------------------------
interface switch_debounce_and_if;
    logic i_Switch_1;
    logic i_Switch_2;
    logic o_Switch_1;
    logic o_Switch_2;
    logic o_Rise_1;
    logic o_Fall_1;
    logic o_Rise_2;
    logic o_Fall_2;
    logic o_LED_1;
    logic o_LED_2;

    modport master (
        output i_Switch_1,
        output i_Switch_2,
        input  o_Switch_1,
        input  o_Switch_2,
        input  o_Rise_1,
        input  o_Fall_1,
        input  o_Rise_2,
        input  o_Fall_2,
        input  o_LED_1,
        input  o_LED_2
    );

    modport slave (
        input  i_Switch_1,
        input  i_Switch_2,
        output o_Switch_1,
        output o_Switch_2,
        output o_Rise_1,
        output o_Fall_1,
        output o_Rise_2,
        output o_Fall_2,
        output o_LED_1,
        output o_LED_2
    );
endinterface

// File: rtl/switch_debounce_and.sv
// ---------------------------------------------------------------------------
// switch_debounce_and
// Input-side conditioner for two board push-buttons. Each raw switch is
// sampled into the clock domain, then filtered by a stability counter: the
// debounced level only follows the sampled input after DEBOUNCE_LIMIT
// consecutive mismatching samples. Each level change emits a one-cycle
// rise/fall pulse. o_LED_1 is the AND of the debounced levels; o_LED_2
// toggles on every debounced press of switch 1.
//
// Ports:
//   i_Clk  - system clock, rising edge
//   i_Rst  - synchronous, active-high reset
//   sw     - switch_debounce_and_if.slave (raw inputs, conditioned outputs)
//
// Parameters:
//   DEBOUNCE_LIMIT - stable cycles required to accept a new level (>= 2)
//   CNT_W          - width of each per-channel stability counter
//
// Build option:
//   SWITCH_SYNC_2FF_EN - when defined, each raw input passes through a
//   two-flop synchronizer instead of a single sample flop, adding one edge
//   of latency. Debounce and output behaviour are otherwise unchanged.
// ---------------------------------------------------------------------------
module switch_debounce_and #(
    parameter int DEBOUNCE_LIMIT = 250000,
    parameter int CNT_W          = $clog2(DEBOUNCE_LIMIT + 1)
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst,
    switch_debounce_and_if.slave  sw
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_LIMIT - 1);

    // Channel index 0 is switch 1, index 1 is switch 2.
    logic [1:0]       raw;

`ifdef SWITCH_SYNC_2FF_EN
    logic [1:0]       meta_q;
    logic [1:0]       meta_d;
`endif
    logic [1:0]       sync_q;
    logic [1:0]       sync_d;
    logic [CNT_W-1:0] cnt_q [2];
    logic [CNT_W-1:0] cnt_d [2];
    logic [1:0]       level_q;
    logic [1:0]       level_d;
    logic [1:0]       rise_q;
    logic [1:0]       rise_d;
    logic [1:0]       fall_q;
    logic [1:0]       fall_d;
    logic             led2_q;
    logic             led2_d;

    assign raw = {sw.i_Switch_2, sw.i_Switch_1};

    // Input stage
    always_comb begin
`ifdef SWITCH_SYNC_2FF_EN
        meta_d = raw;
        sync_d = meta_q;
`else
        sync_d = raw;
`endif
    end

    // Stability counters. A match with the current level clears the count,
    // so any bounce restarts the qualification window. The counter stops at
    // CNT_LAST, where the new level is accepted and the count cleared, so it
    // can never wrap.
    always_comb begin
        level_d = level_q;
        rise_d  = 2'b00;
        fall_d  = 2'b00;
        for (int ch = 0; ch < 2; ch++) begin
            cnt_d[ch] = cnt_q[ch];
            if (sync_q[ch] == level_q[ch]) begin
                cnt_d[ch] = '0;
            end else if (cnt_q[ch] == CNT_LAST) begin
                level_d[ch] = sync_q[ch];
                cnt_d[ch]   = '0;
                rise_d[ch]  = sync_q[ch];
                fall_d[ch]  = ~sync_q[ch];
            end else begin
                cnt_d[ch] = cnt_q[ch] + CNT_W'(1);
            end
        end
    end

    // Toggle follows the registered rise pulse, so it flips one edge after
    // o_Rise_1 is seen high.
    always_comb begin
        led2_d = led2_q ^ rise_q[0];
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
`ifdef SWITCH_SYNC_2FF_EN
            meta_q <= 2'b00;
`endif
            sync_q   <= 2'b00;
            cnt_q[0] <= '0;
            cnt_q[1] <= '0;
            level_q  <= 2'b00;
            rise_q   <= 2'b00;
            fall_q   <= 2'b00;
            led2_q   <= 1'b0;
        end else begin
`ifdef SWITCH_SYNC_2FF_EN
            meta_q <= meta_d;
`endif
            sync_q   <= sync_d;
            cnt_q[0] <= cnt_d[0];
            cnt_q[1] <= cnt_d[1];
            level_q  <= level_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            led2_q   <= led2_d;
        end
    end

    assign sw.o_Switch_1 = level_q[0];
    assign sw.o_Switch_2 = level_q[1];
    assign sw.o_Rise_1   = rise_q[0];
    assign sw.o_Fall_1   = fall_q[0];
    assign sw.o_Rise_2   = rise_q[1];
    assign sw.o_Fall_2   = fall_q[1];
    assign sw.o_LED_1    = level_q[0] & level_q[1];
    assign sw.o_LED_2    = led2_q;

endmodule

// File: tb/tb_switch_debounce_and.sv
module tb_switch_debounce_and;

    localparam int LIMIT = 4;
`ifdef SWITCH_SYNC_2FF_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    switch_debounce_and_if sw_if ();

    switch_debounce_and #(.DEBOUNCE_LIMIT(LIMIT)) dut (
        .i_Clk (clk),
        .i_Rst (rst),
        .sw    (sw_if.slave)
    );

    int tests = 0;
    int fails = 0;

    // Expected output vector after each edge:
    // {sw1, sw2, rise1, fall1, rise2, fall2, led1, led2}
    logic [7:0] exp_q [$];

    // Reference model: a new level is accepted once the last LIMIT samples
    // reaching the filter all disagree with the current level. The sample
    // path is a plain delay line of DEPTH stages, cleared by reset.
    bit m_pipe  [2][$];
    bit m_level [2];
    int m_run   [2];
    bit m_rise  [2];
    bit m_fall  [2];
    bit m_led2;

    initial begin
        for (int c = 0; c < 2; c++) begin
            m_pipe[c] = {};
            for (int k = 0; k < DEPTH; k++) m_pipe[c].push_back(1'b0);
        end
    end

    always @(posedge clk) begin
        bit raw [2];
        bit seen;
        raw[0] = sw_if.i_Switch_1;
        raw[1] = sw_if.i_Switch_2;
        if (rst) begin
            for (int c = 0; c < 2; c++) begin
                for (int k = 0; k < DEPTH; k++) m_pipe[c][k] = 1'b0;
                m_level[c] = 1'b0;
                m_run[c]   = 0;
                m_rise[c]  = 1'b0;
                m_fall[c]  = 1'b0;
            end
            m_led2 = 1'b0;
        end else begin
            m_led2 = m_led2 ^ m_rise[0];
            for (int c = 0; c < 2; c++) begin
                seen = m_pipe[c].pop_front();
                m_pipe[c].push_back(raw[c]);
                m_rise[c] = 1'b0;
                m_fall[c] = 1'b0;
                if (seen == m_level[c]) begin
                    m_run[c] = 0;
                end else begin
                    m_run[c]++;
                    if (m_run[c] == LIMIT) begin
                        m_level[c] = seen;
                        m_rise[c]  = seen;
                        m_fall[c]  = !seen;
                        m_run[c]   = 0;
                    end
                end
            end
        end
        exp_q.push_back({m_level[0], m_level[1], m_rise[0], m_fall[0],
                         m_rise[1], m_fall[1], m_level[0] & m_level[1], m_led2});
    end

    // Monitor: compares DUT outputs with the model away from the clock edge.
    always @(negedge clk) begin
        logic [7:0] exp_v;
        logic [7:0] act_v;
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            act_v = {sw_if.o_Switch_1, sw_if.o_Switch_2, sw_if.o_Rise_1, sw_if.o_Fall_1,
                     sw_if.o_Rise_2, sw_if.o_Fall_2, sw_if.o_LED_1, sw_if.o_LED_2};
            tests++;
            if (act_v !== exp_v) begin
                fails++;
                $display("FAIL outputs t=%0t got {sw1 sw2 r1 f1 r2 f2 led1 led2}=%b expected %b",
                         $time, act_v, exp_v);
            end
        end
    end

    task automatic hold(input bit s1, input bit s2, input bit r, input int n);
        sw_if.i_Switch_1 = s1;
        sw_if.i_Switch_2 = s2;
        rst              = r;
        repeat (n) @(negedge clk);
    endtask

    int rises1 = 0;
    always @(negedge clk) if (sw_if.o_Rise_1 === 1'b1) rises1++;

    initial begin
        int r0;
        sw_if.i_Switch_1 = 1'b1;
        sw_if.i_Switch_2 = 1'b1;
        @(negedge clk);
        // reset held with switches high, then released with switches still high
        hold(1, 1, 1, 3);
        hold(1, 1, 0, 10);
        hold(0, 0, 0, 10);
        // clean press of switch 1, then release
        r0 = rises1;
        hold(1, 0, 0, 10);
        tests++;
        if (rises1 - r0 != 1) begin
            fails++;
            $display("FAIL press_rise_count got %0d expected 1", rises1 - r0);
        end
        hold(0, 0, 0, 10);
        // short high pulse on switch 1 must be rejected
        r0 = rises1;
        hold(1, 0, 0, LIMIT - 1);
        hold(0, 0, 0, 10);
        tests++;
        if (rises1 - r0 != 0) begin
            fails++;
            $display("FAIL glitch_rise_count got %0d expected 0", rises1 - r0);
        end
        // bounce then stable high
        r0 = rises1;
        hold(1, 0, 0, 1);
        hold(0, 0, 0, 1);
        hold(1, 0, 0, 1);
        hold(0, 0, 0, 1);
        hold(1, 0, 0, 10);
        tests++;
        if (rises1 - r0 != 1) begin
            fails++;
            $display("FAIL bounce_rise_count got %0d expected 1", rises1 - r0);
        end
        hold(0, 0, 0, 10);
        // simultaneous press, then release of switch 2
        hold(1, 1, 0, 10);
        hold(1, 0, 0, 10);
        hold(0, 0, 0, 10);
        // reset in the middle of a switch 2 qualification
        hold(0, 1, 0, 3);
        hold(0, 1, 1, 1);
        hold(0, 1, 0, 10);
        hold(0, 0, 0, 10);
        // randomized holds, occasional reset
        for (int i = 0; i < 500; i++) begin
            hold(1'($urandom), 1'($urandom), ($urandom_range(0, 39) == 0),
                 $urandom_range(1, 2 * LIMIT));
        end
        hold(0, 0, 0, 12);
        tests++;
        if (exp_q.size() > 1) begin
            fails++;
            $display("FAIL scoreboard_drain got %0d pending expected <=1", exp_q.size());
        end
        tests++;
        if (tests < 500) begin
            fails++;
            $display("FAIL compare_count got %0d expected >=500", tests);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/switch_debounce_and.md
Name: switch_debounce_and

Overview:
- Input-side conditioner for the board push-buttons: samples two raw switch inputs and debounces each one with a stability counter.
- Outputs clean levels and one-cycle edge pulses for each switch.
- Drives o_LED_1 with the AND of the debounced switches, and toggles o_LED_2 on each debounced press of switch 1.
- Sits between the board pins and any switch-consuming logic. It is the filtering counterpart to gate logic that consumes switch levels.

Parameters:
- DEBOUNCE_LIMIT, 250000, number of consecutive stable cycles required before a debounced level changes (10 ms at 25 MHz). Must be >= 2.
- CNT_W, $clog2(DEBOUNCE_LIMIT+1), width of each per-channel stability counter.

Ports:
- i_Clk  in  1  system clock; all logic is on the rising edge.
- i_Rst  in  1  synchronous, active-high reset.
- i_Switch_1  in  1  raw, asynchronous switch 1 input.
- i_Switch_2  in  1  raw, asynchronous switch 2 input.
- o_Switch_1  out  1  debounced level of switch 1.
- o_Switch_2  out  1  debounced level of switch 2.
- o_Rise_1 / o_Fall_1  out  1  one-cycle pulse when o_Switch_1 goes 0->1 / 1->0.
- o_Rise_2 / o_Fall_2  out  1  one-cycle pulse when o_Switch_2 goes 0->1 / 1->0.
- o_LED_1  out  1  o_Switch_1 AND o_Switch_2.
- o_LED_2  out  1  toggle register, flipped on each o_Rise_1.

Behaviour:
- Reset (i_Rst=1 at an edge): synchronizer flops, counters, debounced levels, edge pulses and the o_LED_2 toggle all go to 0. Every output reads 0 the cycle after.
- Reset mid-debounce discards any partial count; no output changes when reset releases.
- Input stage: one register per channel (r_Sync_n) samples the raw switch each edge.
- Per channel, evaluated every edge using r_Sync_n, the count and the debounced level:
  - sync == level: count <= 0.
  - sync != level and count < DEBOUNCE_LIMIT-1: count <= count+1.
  - sync != level and count == DEBOUNCE_LIMIT-1: level <= sync; count <= 0; the matching Rise/Fall pulse is registered 1 for exactly this cycle.
- Latency: a clean input change captured at edge 0 changes o_Switch_n after edge DEBOUNCE_LIMIT (DEBOUNCE_LIMIT+1 edges in total). The Rise/Fall pulse is high in the same cycle as the level change.
- Glitch rejection: any input pulse shorter than DEBOUNCE_LIMIT sampled cycles produces no output change. The counter restarts from 0 when the input returns to match the level.
- Bounce: each mismatch/match alternation restarts the count, so only the final stable level is accepted.
- Channels are fully independent. Simultaneous changes on both switches debounce in parallel and can pulse in the same cycle.
- Counter never exceeds DEBOUNCE_LIMIT-1, so there is no wrap-around.
- o_LED_1 is combinational from the two debounced level registers. No extra latency.
- o_LED_2 inverts on the edge after each o_Rise_1 pulse. Rise and Fall of one channel are mutually exclusive.

Optional Feature:
- Macro: SWITCH_SYNC_2FF_EN.
- Defined: input stage is two flops per channel (metastability synchronizer). Total latency becomes DEBOUNCE_LIMIT+2 edges; both flops reset to 0.
- Undefined: single sample flop as described above.
- Debounce and output behaviour are otherwise identical.

Test Plan (DEBOUNCE_LIMIT=4, macro undefined unless stated):
- Reset held 3 cycles with i_Switch_1=i_Switch_2=1 -> all outputs 0 throughout reset; no output change when reset releases.
- i_Switch_1 0->1, held stable -> o_Switch_1=1 and o_Rise_1=1 for one cycle, 5 edges after the change; o_LED_2 0->1 on the next edge; o_LED_1 stays 0.
- i_Switch_1 high-pulse of 3 cycles -> o_Switch_1 stays 0; no Rise/Fall pulse.
- Bounce 1,0,1,0 per cycle then stable 1 -> exactly one o_Rise_1, 5 edges after the last transition.
- Both switches 0->1 on the same cycle -> o_Rise_1 and o_Rise_2 in the same cycle; o_LED_1=1 that cycle. Release switch 2 -> o_Fall_2 pulse and o_LED_1=0, 5 edges later.
- Reset asserted when count=2 during a switch 2 press, released, input still 1 -> o_Switch_2 rises 5 edges after reset releases. SWITCH_SYNC_2FF_EN defined -> the same press needs 6 edges.
